gpu_instruction_dispatcher: RTL
===============================

// Module: gpu_instruction_dispatcher
// PURPOSE
// - Upstream feeder of gpuLinker: buffers host-written 32-bit GPU instructions in a FIFO.
// - Issues them one at a time on gpuLinker's instruction/executeInstruction/coresReady handshake.
// - Holds each instruction stable until the core array reports completion, then issues the next.
// PARAMETERS
// - FIFO_DEPTH    16  instruction entries, power of 2, >=2
// - BUSY_TIMEOUT  8   cycles to wait for coresReady to fall before treating the op as instant (>=1)
// - CNT_W         16  width of issuedCount (wraps)
// PORTS
// - clk              in   1           single clock, rising edge
// - reset            in   1           asynchronous, active-high
// - hostInstruction  in   32          instruction word from host
// - hostValid        in   1           push request
// - hostReady        out  1           FIFO not full (combinational from count)
// - instruction      out  32          registered, to gpuLinker.instruction
// - executeInstruction out 1          registered 1-cycle pulse, to gpuLinker
// - coresReady       in   1           from gpuLinker, 1 = all cores idle
// - fifoCount        out  $clog2(FIFO_DEPTH)+1  occupancy
// - dispatchBusy     out  1           state != IDLE
// - issuedCount      out  CNT_W       instructions issued since reset
// - stallCycles      out  32          present only with GPU_DISPATCH_PERF_EN
// BEHAVIOUR
// - Reset values (async, immediate): instruction=0, executeInstruction=0, fifoCount=0, issuedCount=0,
//   stallCycles=0, state=IDLE, pointers=0; hostReady=1.
// - Reset mid-operation: in-flight and queued instructions are discarded; no pulse is generated afterwards.
// - Push: occurs when hostValid && hostReady at a rising edge.
//   - When full, the push is dropped even if a pop occurs in the same cycle.
// - Pop: occurs only in IDLE when fifoCount!=0 && coresReady.
//   - Same-cycle push+pop: count unchanged, both take effect.
//   - A push into an empty FIFO becomes poppable next edge.
// - Pointers wrap modulo FIFO_DEPTH. Entries are issued in FIFO order.
// - FSM:
//   - IDLE: on pop, instruction<=head entry, go to SETUP.
//   - SETUP: 1 cycle, instruction stable, executeInstruction=0, go to PULSE.
//   - PULSE: executeInstruction=1 for exactly 1 cycle, issuedCount++, timer=0, go to WAIT_BUSY.
//   - WAIT_BUSY:
//     - coresReady==0: go to WAIT_READY.
//     - Otherwise timer++; at timer==BUSY_TIMEOUT-1, go to IDLE.
//   - WAIT_READY: coresReady==1, go to IDLE.
// - Latency: push at edge N into an empty FIFO with an idle FSM gives SETUP at N+1 and executeInstruction high N+2..N+3.
// - instruction holds its value from SETUP until the next pop. It is never changed while state!=IDLE.
// - coresReady low in IDLE: no pop; FSM waits.
// - issuedCount wraps 2^CNT_W-1 -> 0.
// CONFIGURATION
// - GPU_DISPATCH_PERF_EN defined:
//   - stallCycles counts cycles with fifoCount!=0 && state==IDLE && !coresReady.
//   - Saturates at 32'hFFFF_FFFF.
// - GPU_DISPATCH_PERF_EN undefined: stallCycles port and counter are absent. All else is identical.
// TESTING
// - Single issue: push 32'h1700_0001 at N, coresReady=1 -> instruction=32'h1700_0001 from N+1,
//   executeInstruction=1 only at N+2, issuedCount=1.
// - Busy handshake: after pulse drive coresReady=0 for 20 cycles, push 2nd word.
//   -> No second pulse until 3 cycles after coresReady returns 1; instruction unchanged meanwhile.
// - Timeout: coresReady held 1 -> next queued word pulses BUSY_TIMEOUT+3=11 cycles after the previous pulse.
// - Full: coresReady=0, push 17 words with FIFO_DEPTH=16.
//   -> hostReady=0 after 16th, 17th dropped, fifoCount=16; release gives 16 pulses in order.
// - Reset mid-op: assert reset during WAIT_READY with 5 queued.
//   -> executeInstruction=0, fifoCount=0, issuedCount=0 immediately; no pulses after release.
// - Perf (GPU_DISPATCH_PERF_EN): 1 queued word, coresReady=0 for 7 IDLE cycles -> stallCycles=7.

Source files
------------

// File: rtl/gpu_instruction_dispatcher.sv
// Instruction FIFO feeding gpuLinker: buffers host words and issues them one at a time.
// Latency: push into empty FIFO with idle FSM -> instruction valid +1 cycle, executeInstruction pulse +2 cycles.
// Backpressure: hostReady drops when the FIFO is full; issue waits for coresReady and for the previous op to finish.
// Optional feature macro: GPU_DISPATCH_PERF_EN adds the stallCycles counter/port.
module gpu_instruction_dispatcher #(
  parameter int FIFO_DEPTH   = 16,
  parameter int BUSY_TIMEOUT = 8,
  parameter int CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   hostInstruction,
  input  logic                          hostValid,
  output logic                          hostReady,
  output logic [31:0]                   instruction,
  output logic                          executeInstruction,
  input  logic                          coresReady,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic                          dispatchBusy,
  output logic [CNT_W-1:0]              issuedCount
`ifdef GPU_DISPATCH_PERF_EN
  ,
  output logic [31:0]                   stallCycles
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_WAIT_BUSY,
    S_WAIT_READY
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [TW-1:0]   timer;
  logic            push;
  logic            pop;

  // Full check comes from the registered count only, so a same-cycle pop never frees a slot for a push.
  assign hostReady    = (count != (AW+1)'(FIFO_DEPTH));
  assign push         = hostValid && hostReady;
  assign pop          = (state_q == S_IDLE) && (count != '0) && coresReady;
  assign fifoCount    = count;
  assign dispatchBusy = (state_q != S_IDLE);

  // Instruction storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= hostInstruction;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for the issue handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_SETUP;
      end
      S_SETUP: begin
        state_d = S_PULSE;
      end
      S_PULSE: begin
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // A core array that never drops coresReady is treated as having finished instantly.
        if (!coresReady) begin
          state_d = S_WAIT_READY;
        end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_READY: begin
        if (coresReady) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs: instruction latched on pop, one-cycle execute pulse, issue counter, busy timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instruction        <= '0;
      executeInstruction <= 1'b0;
      issuedCount        <= '0;
      timer              <= '0;
    end else begin
      if (pop) instruction <= mem[rd_ptr];
      executeInstruction <= (state_q == S_SETUP);
      if (state_q == S_PULSE) begin
        issuedCount <= issuedCount + CNT_W'(1);
        timer       <= '0;
      end else if (state_q == S_WAIT_BUSY && coresReady) begin
        timer <= timer + TW'(1);
      end
    end
  end

`ifdef GPU_DISPATCH_PERF_EN
  // Cycles where work is queued but the cores are not ready to accept it; saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCycles <= '0;
    end else if ((count != '0) && (state_q == S_IDLE) && !coresReady && (stallCycles != 32'hFFFF_FFFF)) begin
      stallCycles <= stallCycles + 32'd1;
    end
  end
`endif

endmodule
